// File: rtl/cpu_pkg.sv
// Shared core types: decoded operation codes, memory-request FSM states
// and small helpers that classify memory operations.
// The ERR state exists only when MISALIGN_CHECK_EN is defined.
package cpu_pkg;

  // Decoded operation of the instruction currently held for decode
  typedef enum logic [5:0] {
    CU_ERROR,
    CU_ADD,  CU_SUB,  CU_AND,  CU_OR,   CU_XOR,
    CU_SLL,  CU_SRL,  CU_SRA,  CU_SLT,  CU_SLTU,
    CU_ADDI, CU_ANDI, CU_ORI,  CU_XORI,
    CU_SLLI, CU_SRLI, CU_SRAI, CU_SLTI, CU_SLTIU,
    CU_LUI,  CU_AUIPC, CU_JAL, CU_JALR,
    CU_BEQ,  CU_BNE,  CU_BLT,  CU_BGE,  CU_BLTU, CU_BGEU,
    CU_LB,   CU_LH,   CU_LW,   CU_LBU,  CU_LHU,
    CU_SB,   CU_SH,   CU_SW
  } cuOPType;

  // Bus sequencing states
`ifdef MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    DATA,
    DONE,
    ERR
  } reqState;
`else
  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    DATA,
    DONE
  } reqState;
`endif

  // Width of a data access
  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } accSize;

  localparam logic [3:0]  SEL_ALL  = 4'b1111;
  localparam logic [3:0]  SEL_NONE = 4'b0000;
  localparam logic [31:0] WORD_ZERO = 32'h0000_0000;

  function automatic logic is_load_op(cuOPType op);
    return (op == CU_LB) || (op == CU_LH) || (op == CU_LW) ||
           (op == CU_LBU) || (op == CU_LHU);
  endfunction

  function automatic logic is_store_op(cuOPType op);
    return (op == CU_SB) || (op == CU_SH) || (op == CU_SW);
  endfunction

  function automatic accSize op_size(cuOPType op);
    case (op)
      CU_LB, CU_LBU, CU_SB: return SZ_BYTE;
      CU_LH, CU_LHU, CU_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic for data accesses: lane enables, store
// data replication across lanes and load lane extraction with sign or
// zero extension.
module load_store_align
  import cpu_pkg::*;
(
  input  cuOPType     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rd_data,
  output logic [3:0]  sel,
  output logic [31:0] wr_data,
  output logic [31:0] ld_data
);

  accSize             acc_size;
  logic signed [7:0]  lane_byte;
  logic signed [15:0] lane_half;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  assign acc_size = op_size(op);

  // Lane enables; misaligned halves/words simply truncate the address
  always_comb begin
    sel = SEL_ALL;
    case (acc_size)
      SZ_BYTE: sel = 4'b0001 << addr_lo;
      SZ_HALF: sel = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: sel = SEL_ALL;
    endcase
  end

  // Replicate narrow store data so every enabled lane sees the right bits
  always_comb begin
    wr_data = store_data;
    case (acc_size)
      SZ_BYTE: wr_data = {4{store_data[7:0]}};
      SZ_HALF: wr_data = {2{store_data[15:0]}};
      default: wr_data = store_data;
    endcase
  end

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = rd_data[7:0];
      2'd1:    lane_byte = rd_data[15:8];
      2'd2:    lane_byte = rd_data[23:16];
      default: lane_byte = rd_data[31:24];
    endcase
    lane_half = addr_lo[1] ? rd_data[31:16] : rd_data[15:0];
    byte_sx   = 32'(lane_byte);
    half_sx   = 32'(lane_half);
    case (op)
      CU_LB:   ld_data = byte_sx;
      CU_LBU:  ld_data = {24'h000000, lane_byte};
      CU_LH:   ld_data = half_sx;
      CU_LHU:  ld_data = {16'h0000, lane_half};
      default: ld_data = rd_data;
    endcase
  end

endmodule

// File: rtl/mem_request_unit.sv
// Shares the single memory bus between instruction fetch and one data
// access per instruction, then emits the one-cycle iready commit strobe.
// Optional feature: MISALIGN_CHECK_EN adds misalignment detection, the
// sticky ERR state and the err output.
module mem_request_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCaddr,
  input  cuOPType     cuOP,
  input  logic [31:0] dataAddr,
  input  logic [31:0] storeData,
  output logic [31:0] instr,
  output logic        iready,
  output logic        dready,
  output logic [31:0] loadData,
  input  logic        busy_i,
  input  logic [31:0] dat_i,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o
`ifdef MISALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  reqState     state;
  reqState     state_nxt;
  logic        is_ld;
  logic        is_st;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  lane_sel;
  logic [31:0] st_data;
  logic [31:0] ld_extract;

  assign is_ld  = is_load_op(cuOP);
  assign is_st  = is_store_op(cuOP);
  assign is_mem = is_ld || is_st;

`ifdef MISALIGN_CHECK_EN
  accSize acc_size;
  assign acc_size   = op_size(cuOP);
  assign misaligned = is_mem &&
                      (((acc_size == SZ_HALF) && dataAddr[0]) ||
                       ((acc_size == SZ_WORD) && (dataAddr[1:0] != 2'b00)));
  assign err        = (state == ERR);
`else
  assign misaligned = 1'b0;
`endif

  load_store_align u_align (
    .op         (cuOP),
    .addr_lo    (dataAddr[1:0]),
    .store_data (storeData),
    .rd_data    (dat_i),
    .sel        (lane_sel),
    .wr_data    (st_data),
    .ld_data    (ld_extract)
  );

  // State register; reset abandons any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: each bus state waits for the first non-busy cycle
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (!busy_i) state_nxt = DECODE;
      DECODE: begin
`ifdef MISALIGN_CHECK_EN
        if (misaligned)  state_nxt = ERR;
        else
`endif
        if (is_mem)      state_nxt = DATA;
        else             state_nxt = FETCH;
      end
      DATA:   if (!busy_i) state_nxt = DONE;
      DONE:   state_nxt = FETCH;
`ifdef MISALIGN_CHECK_EN
      ERR:    state_nxt = ERR;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  // Bus strobes and commit strobes decoded from the current state
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    adr_o     = WORD_ZERO;
    sel_o     = SEL_NONE;
    dat_o     = WORD_ZERO;
    iready    = 1'b0;
    dready    = 1'b0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        adr_o    = PCaddr;
        sel_o    = SEL_ALL;
      end
      DECODE: begin
        // misaligned ops are memory ops, so they never commit here
        iready = !is_mem && !misaligned;
      end
      DATA: begin
        mem_read  = is_ld;
        mem_write = is_st;
        adr_o     = {dataAddr[31:2], 2'b00};
        sel_o     = lane_sel;
        dat_o     = is_st ? st_data : WORD_ZERO;
      end
      DONE: begin
        iready = 1'b1;
        dready = is_ld;
      end
      default: ;
    endcase
  end

  // Instruction and load result registers, written on completing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      instr    <= WORD_ZERO;
      loadData <= WORD_ZERO;
    end else begin
      if ((state == FETCH) && !busy_i) begin
        instr <= dat_i;
      end
      if ((state == DATA) && !busy_i && is_ld) begin
        loadData <= ld_extract;
      end
    end
  end

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench for mem_request_unit: an instruction list is expanded by
// a transaction-level model into a per-cycle schedule of inputs and
// expected outputs, which one compare process checks every cycle.
module tb_mem_request_unit;
  import cpu_pkg::*;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic [31:0] PCaddr;
  cuOPType     cuOP;
  logic [31:0] dataAddr;
  logic [31:0] storeData;
  logic [31:0] instr;
  logic        iready;
  logic        dready;
  logic [31:0] loadData;
  logic        busy_i;
  logic [31:0] dat_i;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
`ifdef MISALIGN_CHECK_EN
  logic        err;
`endif

  always #5 tb_clk = ~tb_clk;

  mem_request_unit dut (
    .clk       (tb_clk),
    .rst       (rst),
    .PCaddr    (PCaddr),
    .cuOP      (cuOP),
    .dataAddr  (dataAddr),
    .storeData (storeData),
    .instr     (instr),
    .iready    (iready),
    .dready    (dready),
    .loadData  (loadData),
    .busy_i    (busy_i),
    .dat_i     (dat_i),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o)
`ifdef MISALIGN_CHECK_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    cuOPType     op;
    logic [31:0] pc, word, daddr, sdata, rdata;
    int          fbusy, dbusy, rst_at;
    logic        mis;
  } ins_t;

  typedef struct {
    logic        rst, busy;
    logic [31:0] pc, din, daddr, sdata;
    cuOPType     op;
    logic        rd, wr, bus;
    logic [31:0] adr, dout;
    logic [3:0]  sel;
    logic        ir, dr, er;
    logic [31:0] ins, ld;
  } cyc_t;

  cyc_t        sched[$];
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_ld    = 32'h0;
  int          n_chk = 0;
  int          n_err = 0;
  int          cur   = -1;
  int          n_ir  = 0;
  int          n_dr  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (step %0d)", nm, act, exp, cur);
    end
  endtask

  // ---- behavioural model: access described by byte count and offset ----
  function automatic logic m_is_load(cuOPType op);
    return op == CU_LB || op == CU_LH || op == CU_LW || op == CU_LBU || op == CU_LHU;
  endfunction

  function automatic logic m_is_store(cuOPType op);
    return op == CU_SB || op == CU_SH || op == CU_SW;
  endfunction

  function automatic int m_bytes(cuOPType op);
    if (op == CU_LB || op == CU_LBU || op == CU_SB) return 1;
    if (op == CU_LH || op == CU_LHU || op == CU_SH) return 2;
    return 4;
  endfunction

  function automatic int m_base(cuOPType op, logic [31:0] a);
    int n;
    n = m_bytes(op);
    if (n == 4) return 0;
    if (n == 2) return a[1] ? 2 : 0;
    return int'(a[1:0]);
  endfunction

  function automatic logic [3:0] m_sel(cuOPType op, logic [31:0] a);
    logic [3:0] s;
    int b, n;
    s = 4'b0000;
    b = m_base(op, a);
    n = m_bytes(op);
    for (int i = 0; i < n; i++) s[b + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(cuOPType op, logic [31:0] d);
    logic [31:0] r;
    int n;
    n = m_bytes(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(cuOPType op, logic [31:0] a, logic [31:0] d);
    logic [31:0] v;
    int b, n;
    v = 32'h0;
    b = m_base(op, a);
    n = m_bytes(op);
    for (int i = 0; i < n; i++) v[8*i +: 8] = d[8*(b + i) +: 8];
    if ((op == CU_LB || op == CU_LH) && v[8*n - 1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic cyc_t blank(ins_t p);
    cyc_t c;
    c.rst = 1'b0; c.busy = 1'b0; c.pc = p.pc; c.din = 32'h0;
    c.daddr = p.daddr; c.sdata = p.sdata; c.op = p.op;
    c.rd = 1'b0; c.wr = 1'b0; c.bus = 1'b0; c.adr = 32'h0; c.dout = 32'h0;
    c.sel = 4'h0; c.ir = 1'b0; c.dr = 1'b0; c.er = 1'b0;
    c.ins = m_instr; c.ld = m_ld;
    return c;
  endfunction

  // Expand one instruction into its expected cycles
  task automatic expand(input ins_t p);
    cyc_t c;
    logic ld, st;
    ld = m_is_load(p.op);
    st = m_is_store(p.op);
    for (int i = 0; i <= p.fbusy; i++) begin
      c = blank(p);
      c.busy = (i < p.fbusy);
      c.din = c.busy ? 32'hDEADBEEF : p.word;
      c.rd = 1'b1; c.bus = 1'b1; c.adr = p.pc; c.sel = 4'hF;
      sched.push_back(c);
    end
    m_instr = p.word;
    c = blank(p);
    c.busy = 1'b1;              // busy is irrelevant outside bus cycles
    c.ir = !(ld || st);
    sched.push_back(c);
    if (p.mis) begin
      for (int i = 0; i < 4; i++) begin
        c = blank(p);
        c.er = 1'b1;
        c.rst = (i == 3);
        sched.push_back(c);
      end
      m_instr = 32'h0;
      m_ld = 32'h0;
      return;
    end
    if (!(ld || st)) return;
    for (int i = 0; i <= p.dbusy; i++) begin
      c = blank(p);
      c.busy = (i < p.dbusy);
      c.din = c.busy ? 32'hDEADBEEF : p.rdata;
      c.rd = ld; c.wr = st; c.bus = 1'b1;
      c.adr = {p.daddr[31:2], 2'b00};
      c.sel = m_sel(p.op, p.daddr);
      c.dout = st ? m_wdata(p.op, p.sdata) : 32'h0;
      if (i == p.rst_at) begin
        c.rst = 1'b1;
        sched.push_back(c);
        m_instr = 32'h0;
        m_ld = 32'h0;
        return;
      end
      sched.push_back(c);
    end
    if (ld) m_ld = m_load(p.op, p.daddr, p.rdata);
    c = blank(p);
    c.ir = 1'b1;
    c.dr = ld;
    sched.push_back(c);
  endtask

  task automatic add(input cuOPType op, input logic [31:0] pc, word, daddr, sdata, rdata,
                     input int fb, db, ra, input logic mis);
    ins_t p;
    p.op = op; p.pc = pc; p.word = word; p.daddr = daddr; p.sdata = sdata;
    p.rdata = rdata; p.fbusy = fb; p.dbusy = db; p.rst_at = ra; p.mis = mis;
    expand(p);
  endtask

  // Compare process: every scheduled cycle, sampled mid-cycle
  always @(negedge tb_clk) begin
    cyc_t c;
    if (cur >= 0) begin
      c = sched[cur];
      chk("mem_read", {31'h0, mem_read}, {31'h0, c.rd});
      chk("mem_write", {31'h0, mem_write}, {31'h0, c.wr});
      if (c.bus) begin
        chk("adr_o", adr_o, c.adr);
        chk("sel_o", {28'h0, sel_o}, {28'h0, c.sel});
      end
      chk("dat_o", dat_o, c.dout);
      chk("iready", {31'h0, iready}, {31'h0, c.ir});
      chk("dready", {31'h0, dready}, {31'h0, c.dr});
      chk("instr", instr, c.ins);
      chk("loadData", loadData, c.ld);
`ifdef MISALIGN_CHECK_EN
      chk("err", {31'h0, err}, {31'h0, c.er});
`endif
      if (iready) n_ir++;
      if (dready) n_dr++;
    end
  end

  initial begin
    int exp_ir;
    rst = 1'b1; PCaddr = 32'h0; cuOP = CU_ADDI; dataAddr = 32'h0;
    storeData = 32'h0; busy_i = 1'b0; dat_i = 32'h0;

    // Literal pins on the model itself
    chk("model_lb", m_load(CU_LB, 32'h103, 32'h80FF_0000), 32'hFFFF_FF80);
    chk("model_lhu", m_load(CU_LHU, 32'h402, 32'hF00D_8001), 32'h0000_F00D);
    chk("model_sel_sh", {28'h0, m_sel(CU_SH, 32'h202)}, 32'h0000_000C);
    chk("model_wdata_sh", m_wdata(CU_SH, 32'h1234_ABCD), 32'hABCD_ABCD);

    //   op       pc     word          daddr   sdata          rdata         fb db rst mis
    add(CU_ADDI, 32'h00, 32'h00500093, 32'h0,   32'h0,         32'h0,        0, 0, -1, 1'b0);
    add(CU_ADD,  32'h04, 32'h002081B3, 32'h0,   32'h0,         32'h0,        3, 0, -1, 1'b0);
    add(CU_LB,   32'h08, 32'h10300083, 32'h103, 32'h0,         32'h80FF0000, 0, 0, -1, 1'b0);
    add(CU_SH,   32'h0C, 32'h20209123, 32'h202, 32'h1234ABCD,  32'h0,        0, 2, -1, 1'b0);
    add(CU_LHU,  32'h10, 32'h40205083, 32'h402, 32'h0,         32'hF00D8001, 0, 0, -1, 1'b0);
    add(CU_LH,   32'h14, 32'h50001083, 32'h500, 32'h0,         32'h12348765, 0, 1, -1, 1'b0);
    add(CU_LBU,  32'h18, 32'h60104083, 32'h601, 32'h0,         32'h0000C300, 0, 0, -1, 1'b0);
    add(CU_SB,   32'h1C, 32'h70208123, 32'h702, 32'h000000A5,  32'h0,        0, 0, -1, 1'b0);
    add(CU_LW,   32'h20, 32'h80002083, 32'h800, 32'h0,         32'hCAFEF00D, 1, 1, -1, 1'b0);
    add(CU_SW,   32'h24, 32'h90402223, 32'h904, 32'h11223344,  32'h0,        0, 0, -1, 1'b0);
    add(CU_ERROR,32'h28, 32'hFFFFFFFF, 32'h0,   32'h0,         32'h0,        0, 0, -1, 1'b0);
    add(CU_LW,   32'h2C, 32'hA0002083, 32'hA00, 32'h0,         32'h55555555, 0, 4,  1, 1'b0);
    add(CU_ADDI, 32'h30, 32'h00100113, 32'h0,   32'h0,         32'h0,        0, 0, -1, 1'b0);
    exp_ir = 12;
`ifdef MISALIGN_CHECK_EN
    add(CU_LW,   32'h34, 32'h30002083, 32'h302, 32'h0,         32'h0,        0, 0, -1, 1'b1);
    add(CU_ADDI, 32'h38, 32'h00200193, 32'h0,   32'h0,         32'h0,        0, 0, -1, 1'b0);
    exp_ir = 13;
`endif

    // Reset phase: two edges with rst high, reset values checked between
    @(posedge tb_clk);
    @(negedge tb_clk);
    chk("rst_instr", instr, 32'h0);
    chk("rst_loadData", loadData, 32'h0);
    chk("rst_iready", {31'h0, iready}, 32'h0);
    chk("rst_dready", {31'h0, dready}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);

    for (int k = 0; k < sched.size(); k++) begin
      @(posedge tb_clk);
      #1;
      rst       = sched[k].rst;
      busy_i    = sched[k].busy;
      dat_i     = sched[k].din;
      PCaddr    = sched[k].pc;
      cuOP      = sched[k].op;
      dataAddr  = sched[k].daddr;
      storeData = sched[k].sdata;
      cur       = k;
    end
    @(posedge tb_clk);
    #1;
    cur = -1;
    rst = 1'b0;

    chk("iready_total", n_ir, exp_ir);
    chk("dready_total", n_dr, 5);
    chk("final_instr", instr, sched[sched.size() - 1].ins);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
